// File: rtl/muldiv_pkg.sv
// Shared encodings and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_OP_WIDTH = 2;

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_val,
    input  logic             neg,
    output logic [WIDTH-1:0] out_val
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        if (neg) begin
            out_val = ~in_val + WIDTH'(1'b1);
        end else begin
            out_val = in_val;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing HI/LO for MULT, MULTU, DIV and DIVU.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle combinational multiplier.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic                   cancel,
    input  logic [DATA_WIDTH-1:0]  src_a,
    input  logic [DATA_WIDTH-1:0]  src_b,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  hi_out,
    output logic [DATA_WIDTH-1:0]  lo_out,
    output logic                   we_hi,
    output logic                   we_lo
);

    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    md_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W2:0]          acc_q, acc_d;
    logic [W:0]           opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 div0_q, div0_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [W-1:0]         hi_q, hi_d;
    logic [W-1:0]         lo_q, lo_d;

    logic                 sign_a_s, sign_b_s;
    logic [W:0]           mag_a_s, mag_b_s;
    logic [W:0]           mul_sum_s;
    logic [W2:0]          mul_next_s;
    logic [W:0]           div_shift_s, div_sub_s, div_rem_s;
    logic                 div_ge_s;
    logic [W2:0]          div_next_s;
    logic [W2-1:0]        prod_fix_s;
    logic [W-1:0]         quot_fix_s, rem_fix_s;

    assign sign_a_s = md_is_signed(op) & src_a[W-1];
    assign sign_b_s = md_is_signed(op) & src_b[W-1];

    // Signed operands are sign-extended to W+1 bits first so |MIN| is representable.
    muldiv_signfix #(.WIDTH(W + 1)) u_mag_a (
        .in_val  ({sign_a_s, src_a}),
        .neg     (sign_a_s),
        .out_val (mag_a_s)
    );

    muldiv_signfix #(.WIDTH(W + 1)) u_mag_b (
        .in_val  ({sign_b_s, src_b}),
        .neg     (sign_b_s),
        .out_val (mag_b_s)
    );

    muldiv_signfix #(.WIDTH(W2)) u_fix_prod (
        .in_val  (acc_q[W2-1:0]),
        .neg     (neg_q),
        .out_val (prod_fix_s)
    );

    muldiv_signfix #(.WIDTH(W)) u_fix_quot (
        .in_val  (acc_q[W-1:0]),
        .neg     (neg_q),
        .out_val (quot_fix_s)
    );

    muldiv_signfix #(.WIDTH(W)) u_fix_rem (
        .in_val  (acc_q[W2-1:W]),
        .neg     (rem_neg_q),
        .out_val (rem_fix_s)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0] fast_prod_s;
    assign fast_prod_s = W2'(mag_a_s[W-1:0]) * W2'(mag_b_s[W-1:0]);
`endif

    // Shift-add step: acc holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum_s = acc_q[W2:W] + opnd_q;
        if (acc_q[0]) begin
            mul_next_s = {1'b0, mul_sum_s, acc_q[W-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_q[W2:W], acc_q[W-1:1]};
        end
    end

    // Restoring divide step: acc holds {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        div_shift_s = acc_q[W2-1:W-1];
        div_sub_s   = div_shift_s - opnd_q;
        div_ge_s    = (div_shift_s >= opnd_q);
        if (div_ge_s) begin
            div_rem_s = div_sub_s;
        end else begin
            div_rem_s = div_shift_s;
        end
        div_next_s = {div_rem_s, acc_q[W-2:0], div_ge_s};
    end

    // Next-state, datapath and output-register logic for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else if (start) begin
                    is_div_d  = md_is_div(op);
                    opnd_d    = md_is_div(op) ? mag_b_s : mag_a_s;
                    acc_d     = {{(W + 1){1'b0}}, md_is_div(op) ? mag_a_s[W-1:0] : mag_b_s[W-1:0]};
                    neg_d     = sign_a_s ^ sign_b_s;
                    rem_neg_d = sign_a_s;
                    div0_d    = (src_b == {W{1'b0}});
                    cnt_d     = {CNT_WIDTH{1'b0}};
`ifdef MULDIV_FAST_MUL_EN
                    if (md_is_div(op)) begin
                        state_d = MD_CALC;
                    end else begin
                        state_d = MD_FIX;
                        acc_d   = {1'b0, fast_prod_s};
                    end
`else
                    state_d = MD_CALC;
`endif
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                    cnt_d   = {CNT_WIDTH{1'b0}};
                end else begin
                    acc_d = is_div_q ? div_next_s : mul_next_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d = MD_FIX;
                        cnt_d   = {CNT_WIDTH{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1'b1);
                    end
                end
            end
            MD_FIX: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_DONE;
                    if (is_div_q) begin
                        // A zero divisor leaves |a| as remainder; the sign fix restores src_a.
                        hi_d = rem_fix_s;
                        lo_d = div0_q ? {W{1'b1}} : quot_fix_s;
                    end else begin
                        hi_d = prod_fix_s[W2-1:W];
                        lo_d = prod_fix_s[W-1:0];
                    end
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = {CNT_WIDTH{1'b0}};
            end
        endcase

        busy_d = (state_d == MD_CALC) || (state_d == MD_FIX);
        done_d = (state_d == MD_DONE);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= {CNT_WIDTH{1'b0}};
            acc_q     <= {(W2 + 1){1'b0}};
            opnd_q    <= {(W + 1){1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign we_hi  = done_q;
    assign we_lo  = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
